// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache tag engine: integer typedefs,
// log2 helpers, FSM state encoding and the per-line state record.
package cache_pkg;

    typedef logic [15:0] u16;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    // Widest tag the line record can hold; engines with a narrower tag
    // keep the upper bits at zero so they fold away in synthesis.
    localparam int TAG_MAX_W = 32;

    // Ceiling log2 for elaboration-time width math (log2c(1) = 0).
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Same as log2c but never narrower than one bit, for port/field widths.
    function automatic int log2m1(input int v);
        return (log2c(v) > 0) ? log2c(v) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_state_t;

endpackage

// File: rtl/cache_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module cache_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_tag_engine.sv
// Set-associative tag/state engine: valid/ready request in, one-cycle
// registered response out, true-LRU replacement, write-back dirty tracking.
// Statistics counters exist only when CACHE_STATS_EN is defined; otherwise
// every cnt_* output is tied to zero and clear_stats is ignored.
// Tag width must not exceed cache_pkg::TAG_MAX_W.
module cache_tag_engine
    import cache_pkg::*;
#(
    parameter  int SETS         = 16,
    parameter  int ASSOC        = 2,
    parameter  int LINESIZE     = 128,
    parameter  int ADDRESS_SIZE = 16,
    parameter  int CNT_W        = 32,
    localparam int BS_W         = log2c(LINESIZE),
    localparam int IDX_W        = log2c(SETS),
    localparam int TAG_W        = ADDRESS_SIZE - IDX_W - BS_W,
    localparam int WAY_W        = log2m1(ASSOC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic                    clear_stats,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [WAY_W-1:0]        rsp_way,
    output logic                    rsp_evict,
    output logic                    rsp_writeback,
    output logic [TAG_W-1:0]        rsp_evict_tag,
    output logic [CNT_W-1:0]        cnt_access,
    output logic [CNT_W-1:0]        cnt_read,
    output logic [CNT_W-1:0]        cnt_write,
    output logic [CNT_W-1:0]        cnt_hit,
    output logic [CNT_W-1:0]        cnt_miss,
    output logic [CNT_W-1:0]        cnt_evict,
    output logic [CNT_W-1:0]        cnt_wb
);

    localparam int IDX_WE = (IDX_W > 0) ? IDX_W : 1;
    localparam int AGE_W  = WAY_W;

    // Latched request and FSM state.
    state_t            state_q;
    logic              rw_q;
    logic [IDX_WE-1:0] idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic              req_ready_q;

    // Registered response.
    logic              rsp_valid_q, rsp_hit_q, rsp_evict_q, rsp_writeback_q;
    logic [WAY_W-1:0]  rsp_way_q;
    logic [TAG_W-1:0]  rsp_evict_tag_q;

    // Tag store and LRU ages; age 0 = most recently used.
    line_state_t       lines_q [SETS][ASSOC];
    logic [AGE_W-1:0]  age_q   [SETS][ASSOC];

    // Lookup results for the latched request.
    logic              hit, inv_found;
    logic [WAY_W-1:0]  hit_way, inv_way, lru_way, acc_way;
    logic [AGE_W-1:0]  old_age;
    line_state_t       set_line_d [ASSOC];
    logic [AGE_W-1:0]  set_age_d  [ASSOC];
    logic              rsp_hit_d, rsp_evict_d, rsp_writeback_d;
    logic [TAG_W-1:0]  rsp_evict_tag_d;

    // Address split; byte-offset bits never take part in tag state.
    logic [IDX_WE-1:0] req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_offset;

    assign req_tag       = req_addr[ADDRESS_SIZE-1 -: TAG_W];
    assign unused_offset = ^req_addr[BS_W-1:0];

    generate
        if (IDX_W > 0) begin : g_idx
            assign req_idx = req_addr[BS_W+IDX_W-1:BS_W];
        end else begin : g_no_idx
            assign req_idx = '0;
        end
    endgenerate

    // Hit detection and victim choice: lowest invalid way first, else oldest.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (lines_q[idx_q][w].valid && (lines_q[idx_q][w].tag == TAG_MAX_W'(tag_q))) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!lines_q[idx_q][w].valid && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx_q][w] == AGE_W'(ASSOC - 1)) lru_way = WAY_W'(w);
        end
        acc_way = hit ? hit_way : (inv_found ? inv_way : lru_way);
    end

    // New line state, ages and response fields for the accessed set.
    always_comb begin
        old_age         = age_q[idx_q][acc_way];
        rsp_hit_d       = hit;
        rsp_evict_d     = !hit && lines_q[idx_q][acc_way].valid;
        rsp_writeback_d = rsp_evict_d && lines_q[idx_q][acc_way].dirty;
        rsp_evict_tag_d = rsp_evict_d ? lines_q[idx_q][acc_way].tag[TAG_W-1:0] : '0;
        for (int w = 0; w < ASSOC; w++) begin
            set_line_d[w] = lines_q[idx_q][w];
            set_age_d[w]  = age_q[idx_q][w];
            if (WAY_W'(w) == acc_way) begin
                set_age_d[w] = '0;
                if (hit) begin
                    set_line_d[w].dirty = lines_q[idx_q][w].dirty | rw_q;
                end else begin
                    set_line_d[w].valid = 1'b1;
                    set_line_d[w].dirty = rw_q;
                    set_line_d[w].tag   = TAG_MAX_W'(tag_q);
                end
            end else if (age_q[idx_q][w] < old_age) begin
                set_age_d[w] = age_q[idx_q][w] + AGE_W'(1);
            end
        end
    end

    // Tag store: commit the looked-up set on the LOOKUP edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    lines_q[s][w] <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else if (state_q == LOOKUP) begin
            for (int w = 0; w < ASSOC; w++) begin
                lines_q[idx_q][w] <= set_line_d[w];
                age_q[idx_q][w]   <= set_age_d[w];
            end
        end
    end

    // Request FSM with registered ready and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rw_q            <= 1'b0;
            idx_q           <= '0;
            tag_q           <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_way_q       <= '0;
            rsp_evict_q     <= 1'b0;
            rsp_writeback_q <= 1'b0;
            rsp_evict_tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rw_q        <= req_rw;
                        idx_q       <= req_idx;
                        tag_q       <= req_tag;
                        state_q     <= LOOKUP;
                        req_ready_q <= 1'b0;
                    end
                end
                LOOKUP: begin
                    state_q         <= RESP;
                    rsp_valid_q     <= 1'b1;
                    rsp_hit_q       <= rsp_hit_d;
                    rsp_way_q       <= acc_way;
                    rsp_evict_q     <= rsp_evict_d;
                    rsp_writeback_q <= rsp_writeback_d;
                    rsp_evict_tag_q <= rsp_evict_tag_d;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_way       = rsp_way_q;
    assign rsp_evict     = rsp_evict_q;
    assign rsp_writeback = rsp_writeback_q;
    assign rsp_evict_tag = rsp_evict_tag_q;

`ifdef CACHE_STATS_EN
    // Event strobes, all qualified by the LOOKUP edge.
    logic                  upd;
    logic [6:0]            cnt_inc;
    logic [6:0][CNT_W-1:0] cnt_vec;

    assign upd     = (state_q == LOOKUP);
    assign cnt_inc = {upd & rsp_writeback_d, upd & rsp_evict_d, upd & !hit,
                      upd & hit, upd & rw_q, upd & !rw_q, upd};

    generate
        for (genvar i = 0; i < 7; i++) begin : g_cnt
            cache_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (clear_stats),
                .inc   (cnt_inc[i]),
                .cnt   (cnt_vec[i])
            );
        end
    endgenerate

    assign cnt_access = cnt_vec[0];
    assign cnt_read   = cnt_vec[1];
    assign cnt_write  = cnt_vec[2];
    assign cnt_hit    = cnt_vec[3];
    assign cnt_miss   = cnt_vec[4];
    assign cnt_evict  = cnt_vec[5];
    assign cnt_wb     = cnt_vec[6];
`else
    logic unused_clear;
    assign unused_clear = clear_stats;

    assign cnt_access = '0;
    assign cnt_read   = '0;
    assign cnt_write  = '0;
    assign cnt_hit    = '0;
    assign cnt_miss   = '0;
    assign cnt_evict  = '0;
    assign cnt_wb     = '0;
`endif

endmodule
